// File: rtl/rv_pkg.sv
// Shared types for the decode->execute boundary: the decoded packet that
// travels through the issue register, its control sub-fields, and the
// bypass priority constants used by the forwarding muxes.
package rv_pkg;

  // Storage width for packet addresses/immediates; stages slice to their XLEN.
  localparam int RV_MAX_XLEN = 64;
  localparam int RV_REG_W    = 5;

  // Bypass sources: index 0 is the youngest producer and wins ties.
  localparam int FWD_MAX_PORTS    = 4;
  localparam int FWD_PRIO_HIGHEST = 0;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU,
    RES_MEM,
    RES_PC4,
    RES_CSR
  } res_src_t;

  // Second-operand select: immediate-I, immediate-J, or the rs2 value.
  typedef struct packed {
    logic i;
    logic j;
  } src_op2_t;

  // Result bundle produced by the downstream ALU.
  typedef struct packed {
    logic [RV_MAX_XLEN-1:0] value;
    logic                   zero;
    logic                   lt;
    logic                   ltu;
  } alu_res_t;

  typedef struct packed {
    logic [RV_REG_W-1:0]    rs1;
    logic [RV_REG_W-1:0]    rs2;
    logic [RV_REG_W-1:0]    rd;
    logic [RV_MAX_XLEN-1:0] imm_i;
    logic [RV_MAX_XLEN-1:0] imm_j;
    logic [RV_MAX_XLEN-1:0] pc;
    logic [RV_MAX_XLEN-1:0] pc_next;
    alu_ctrl_t              alu_ctrl;
    res_src_t               res_src;
    logic                   op1_src;
    src_op2_t               op2;
    logic                   reg_we;
    logic                   jal;
    logic                   jalr;
    logic                   mret;
    logic                   branch;
  } dec_pkt_t;

  // Instructions whose computed target must respect instruction alignment.
  function automatic logic is_ctrl_flow(input dec_pkt_t p);
    return p.jal | p.jalr | p.branch;
  endfunction

endpackage

// File: rtl/rv_fwd_mux.sv
// Operand bypass selector: picks the highest-priority matching bypass source
// for one architectural register, falling back to the register file value.
// x0 always reads as zero, whatever a bypass source claims to write.
module rv_fwd_mux
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FWD_PORTS = 2
) (
  input  logic [RV_REG_W-1:0]           rs,
  input  logic [FWD_PORTS-1:0]          fwd_valid,
  input  logic [RV_REG_W*FWD_PORTS-1:0] fwd_rd,
  input  logic [XLEN*FWD_PORTS-1:0]     fwd_data,
  input  logic [XLEN-1:0]               reg_data,
  output logic [XLEN-1:0]               value
);

  // Walk sources from lowest to highest priority so the highest match overwrites.
  always_comb begin
    // NOTE: default assignment first so every path drives value (no latch).
    value = reg_data;
    for (int k = FWD_PORTS - 1; k >= FWD_PRIO_HIGHEST; k--) begin
      if (fwd_valid[k] && (fwd_rd[k*RV_REG_W +: RV_REG_W] == rs)) begin
        value = fwd_data[k*XLEN +: XLEN];
      end
    end
    if (rs == '0) begin
      value = '0;
    end
  end

endmodule

// File: rtl/rv_ex_issue_reg.sv
// Decode->execute issue register. Holds one decoded beat (plus an optional
// one-entry skid) under a valid/ready handshake, and presents the execute
// stage with forwarded operands, muxed ALU inputs and the control-flow target.
// Operand/target logic is combinational off the held packet so late bypass
// data is picked up on every stall cycle.
module rv_ex_issue_reg
  import rv_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int IADDR_SPACE_BITS = 32,
  parameter int FWD_PORTS        = 2,
  parameter int SKID             = 1,
  parameter int C_EXT            = 0,
  parameter int CNT_W            = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_flush,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  dec_pkt_t                      i_pkt,
  output logic                          o_valid,
  input  logic                          i_ready,
  output dec_pkt_t                      o_pkt,
  input  logic [XLEN-1:0]               i_reg1_data,
  input  logic [XLEN-1:0]               i_reg2_data,
  input  logic [FWD_PORTS-1:0]          i_fwd_valid,
  input  logic [5*FWD_PORTS-1:0]        i_fwd_rd,
  input  logic [XLEN*FWD_PORTS-1:0]     i_fwd_data,
  input  logic [IADDR_SPACE_BITS-1:0]   i_ret_addr,
  output logic [XLEN-1:0]               o_op1,
  output logic [XLEN-1:0]               o_op2,
  output logic [XLEN-1:0]               o_reg_data1,
  output logic [XLEN-1:0]               o_reg_data2,
  output logic [IADDR_SPACE_BITS-1:0]   o_pc_target,
  output logic                          o_inst_jal_jalr,
  output logic                          o_target_misalign,
  input  logic                          i_cnt_clr,
  output logic [CNT_W-1:0]              o_stall_cnt
);

  localparam logic                        CHECK_ALIGN = (C_EXT == 0);
  localparam logic [IADDR_SPACE_BITS-1:0] JALR_MASK   = ~IADDR_SPACE_BITS'(1);

  logic accept;
  assign accept = i_valid & o_ready;

  // ---------------------------------------------------------------------------
  // Beat storage
  // ---------------------------------------------------------------------------
  if (SKID != 0) begin : g_skid
    dec_pkt_t skid_pkt;
    logic     skid_valid;

    // Ready comes straight off a flop, breaking the i_ready->o_ready path.
    assign o_ready = !skid_valid;

    // Main register refills from the skid first; skid only catches a beat
    // accepted while main is held by downstream backpressure.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        // NOTE: payload flops are reset too so o_pkt reads zero out of reset.
        o_valid    <= 1'b0;
        o_pkt      <= '0;
        skid_valid <= 1'b0;
        skid_pkt   <= '0;
      end else if (i_flush) begin
        o_valid    <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!o_valid || i_ready) begin
        if (skid_valid) begin
          o_valid    <= 1'b1;
          o_pkt      <= skid_pkt;
          skid_valid <= 1'b0;
        end else begin
          o_valid <= accept;
          if (accept) begin
            o_pkt <= i_pkt;
          end
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_pkt   <= i_pkt;
      end
    end
  end else begin : g_no_skid
    // Without a skid, the stage can take a beat whenever main will be freed.
    assign o_ready = !o_valid || i_ready;

    // Main register loads on every accepted beat.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        o_valid <= 1'b0;
        o_pkt   <= '0;
      end else if (i_flush) begin
        o_valid <= 1'b0;
      end else if (!o_valid || i_ready) begin
        o_valid <= accept;
        if (accept) begin
          o_pkt <= i_pkt;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Backpressure statistics
  // ---------------------------------------------------------------------------

  // Saturating count of cycles a valid beat waits on downstream.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: state uses non-blocking assignment so all flops update together.
      o_stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_stall_cnt <= '0;
    end else if (o_valid && !i_ready && (o_stall_cnt != {CNT_W{1'b1}})) begin
      o_stall_cnt <= o_stall_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Operand forwarding
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  rv_fwd_mux #(
    .XLEN      (XLEN),
    .FWD_PORTS (FWD_PORTS)
  ) u_fwd_rs1 (
    .rs        (o_pkt.rs1),
    .fwd_valid (i_fwd_valid),
    .fwd_rd    (i_fwd_rd),
    .fwd_data  (i_fwd_data),
    .reg_data  (i_reg1_data),
    .value     (fwd_rs1)
  );

  rv_fwd_mux #(
    .XLEN      (XLEN),
    .FWD_PORTS (FWD_PORTS)
  ) u_fwd_rs2 (
    .rs        (o_pkt.rs2),
    .fwd_valid (i_fwd_valid),
    .fwd_rd    (i_fwd_rd),
    .fwd_data  (i_fwd_data),
    .reg_data  (i_reg2_data),
    .value     (fwd_rs2)
  );

  assign o_reg_data1 = fwd_rs1;
  assign o_reg_data2 = fwd_rs2;

  // ---------------------------------------------------------------------------
  // ALU operand muxing
  // ---------------------------------------------------------------------------
  logic [IADDR_SPACE_BITS-1:0] pc_a;
  assign pc_a = o_pkt.pc[IADDR_SPACE_BITS-1:0];

  // op1 is the zero-extended pc (auipc/jal link) or rs1; op2 is an immediate or rs2.
  always_comb begin
    o_op1 = fwd_rs1;
    if (o_pkt.op1_src) begin
      o_op1 = XLEN'(pc_a);
    end
    o_op2 = fwd_rs2;
    if (o_pkt.op2.i) begin
      o_op2 = o_pkt.imm_i[XLEN-1:0];
    end else if (o_pkt.op2.j) begin
      o_op2 = o_pkt.imm_j[XLEN-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control-flow target
  // ---------------------------------------------------------------------------
  logic [IADDR_SPACE_BITS-1:0] jalr_target;
  logic [IADDR_SPACE_BITS-1:0] rel_target;

  assign jalr_target = (fwd_rs1[IADDR_SPACE_BITS-1:0]
                        + o_pkt.imm_i[IADDR_SPACE_BITS-1:0]) & JALR_MASK;
  assign rel_target  = pc_a + o_pkt.imm_j[IADDR_SPACE_BITS-1:0];

  // mret returns to the trap address; jalr is register-relative; the rest pc-relative.
  always_comb begin
    o_pc_target = rel_target;
    if (o_pkt.mret) begin
      o_pc_target = i_ret_addr;
    end else if (o_pkt.jalr) begin
      o_pc_target = jalr_target;
    end
  end

  assign o_inst_jal_jalr   = o_valid & (o_pkt.jal | o_pkt.jalr | o_pkt.mret);
  assign o_target_misalign = o_valid & is_ctrl_flow(o_pkt) & ~o_pkt.mret
                             & CHECK_ALIGN & o_pc_target[1];

endmodule

// File: tb/tb_rv_ex_issue_reg.sv
// Self-checking bench for rv_ex_issue_reg (SKID=1, C_EXT=0, CNT_W=4).
// The reference model treats the stage as a two-deep FIFO of accepted beats
// and computes operands/targets directly from the instruction semantics.
module tb_rv_ex_issue_reg;
  import rv_pkg::*;

  localparam int XLEN = 32;
  localparam int IA   = 32;
  localparam int FP   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  dec_pkt_t          i_pkt;
  logic              o_valid;
  logic              i_ready;
  dec_pkt_t          o_pkt;
  logic [XLEN-1:0]   i_reg1_data;
  logic [XLEN-1:0]   i_reg2_data;
  logic [FP-1:0]     i_fwd_valid;
  logic [5*FP-1:0]   i_fwd_rd;
  logic [XLEN*FP-1:0] i_fwd_data;
  logic [IA-1:0]     i_ret_addr;
  logic [XLEN-1:0]   o_op1;
  logic [XLEN-1:0]   o_op2;
  logic [XLEN-1:0]   o_reg_data1;
  logic [XLEN-1:0]   o_reg_data2;
  logic [IA-1:0]     o_pc_target;
  logic              o_inst_jal_jalr;
  logic              o_target_misalign;
  logic              i_cnt_clr;
  logic [CW-1:0]     o_stall_cnt;

  rv_ex_issue_reg #(
    .XLEN             (XLEN),
    .IADDR_SPACE_BITS (IA),
    .FWD_PORTS        (FP),
    .SKID             (1),
    .C_EXT            (0),
    .CNT_W            (CW)
  ) dut (
    .i_clk             (i_clk),
    .i_reset_n         (i_reset_n),
    .i_flush           (i_flush),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_pkt             (i_pkt),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_pkt             (o_pkt),
    .i_reg1_data       (i_reg1_data),
    .i_reg2_data       (i_reg2_data),
    .i_fwd_valid       (i_fwd_valid),
    .i_fwd_rd          (i_fwd_rd),
    .i_fwd_data        (i_fwd_data),
    .i_ret_addr        (i_ret_addr),
    .o_op1             (o_op1),
    .o_op2             (o_op2),
    .o_reg_data1       (o_reg_data1),
    .o_reg_data2       (o_reg_data2),
    .o_pc_target       (o_pc_target),
    .o_inst_jal_jalr   (o_inst_jal_jalr),
    .o_target_misalign (o_target_misalign),
    .i_cnt_clr         (i_cnt_clr),
    .o_stall_cnt       (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  dec_pkt_t mq[$];   // accepted beats not yet taken downstream, oldest first
  int       m_cnt;
  int       nid;

  function automatic logic [XLEN-1:0] m_fwd(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 5'd0) return '0;
    for (int k = 0; k < FP; k++) begin
      if (i_fwd_valid[k] && (i_fwd_rd[k*5 +: 5] == rs)) return i_fwd_data[k*XLEN +: XLEN];
    end
    return rf;
  endfunction

  task automatic compare_all(input string ph);
    dec_pkt_t        e;
    logic [XLEN-1:0] r1, r2, op1, op2;
    logic [IA-1:0]   tgt;
    check({ph, "_valid"}, 64'(o_valid), 64'(mq.size() != 0));
    check({ph, "_ready"}, 64'(o_ready), 64'(mq.size() < 2));
    check({ph, "_cnt"}, 64'(o_stall_cnt), 64'(m_cnt));
    if (mq.size() != 0) begin
      e   = mq[0];
      r1  = m_fwd(e.rs1, i_reg1_data);
      r2  = m_fwd(e.rs2, i_reg2_data);
      op1 = e.op1_src ? e.pc[XLEN-1:0] : r1;
      op2 = e.op2.i ? e.imm_i[XLEN-1:0] : (e.op2.j ? e.imm_j[XLEN-1:0] : r2);
      if (e.mret)      tgt = i_ret_addr;
      else if (e.jalr) tgt = (r1 + e.imm_i[IA-1:0]) & 32'hFFFF_FFFE;
      else             tgt = e.pc[IA-1:0] + e.imm_j[IA-1:0];
      check({ph, "_pc"}, o_pkt.pc, e.pc);
      check({ph, "_rd"}, 64'(o_pkt.rd), 64'(e.rd));
      check({ph, "_immi"}, o_pkt.imm_i, e.imm_i);
      check({ph, "_rdata1"}, 64'(o_reg_data1), 64'(r1));
      check({ph, "_rdata2"}, 64'(o_reg_data2), 64'(r2));
      check({ph, "_op1"}, 64'(o_op1), 64'(op1));
      check({ph, "_op2"}, 64'(o_op2), 64'(op2));
      check({ph, "_target"}, 64'(o_pc_target), 64'(tgt));
      check({ph, "_jj"}, 64'(o_inst_jal_jalr), 64'(e.jal | e.jalr | e.mret));
      check({ph, "_misalign"}, 64'(o_target_misalign),
            64'((e.jal | e.jalr | e.branch) & ~e.mret & tgt[1]));
    end else begin
      check({ph, "_jj_idle"}, 64'(o_inst_jal_jalr), 64'(0));
      check({ph, "_mis_idle"}, 64'(o_target_misalign), 64'(0));
    end
  endtask

  task automatic model_update();
    bit acc;
    acc = i_valid && (mq.size() < 2);
    if (i_cnt_clr) m_cnt = 0;
    else if ((mq.size() != 0) && !i_ready && (m_cnt < CMAX)) m_cnt++;
    if (i_flush) begin
      mq.delete();
    end else begin
      if ((mq.size() != 0) && i_ready) void'(mq.pop_front());
      if (acc) mq.push_back(i_pkt);
    end
  endtask

  // One clock: compare mid-cycle, advance model at the edge, settle after.
  task automatic cycle(input string ph);
    @(negedge i_clk);
    compare_all(ph);
    @(posedge i_clk);
    model_update();
    #1;
  endtask

  // Upstream only presents a new beat once the current one was taken.
  task automatic beat_cycle(input string ph);
    bit acc;
    acc = i_valid && (mq.size() < 2) && !i_flush;
    cycle(ph);
    if (acc) i_pkt = rand_pkt(nid++);
  endtask

  function automatic dec_pkt_t rand_pkt(input int id);
    dec_pkt_t p;
    int       kind;
    p          = '0;
    p.rs1      = 5'($urandom_range(0, 7));
    p.rs2      = 5'($urandom_range(0, 7));
    p.rd       = 5'($urandom_range(0, 31));
    p.imm_i    = {$urandom, $urandom};
    p.imm_j    = {$urandom, $urandom};
    p.pc       = 64'h1000 + 64'(id) * 64'd4;
    p.pc_next  = p.pc + 64'd4;
    p.alu_ctrl = alu_ctrl_t'(4'($urandom_range(0, 9)));
    p.res_src  = res_src_t'(2'($urandom_range(0, 3)));
    p.op1_src  = 1'($urandom_range(0, 1));
    p.op2.i    = ($urandom_range(0, 2) == 0);
    p.op2.j    = !p.op2.i && ($urandom_range(0, 1) == 1);
    p.reg_we   = 1'($urandom_range(0, 1));
    kind = $urandom_range(0, 4);
    case (kind)
      1:       p.jal    = 1'b1;
      2:       p.jalr   = 1'b1;
      3:       p.mret   = 1'b1;
      4:       p.branch = 1'b1;
      default: ;
    endcase
    return p;
  endfunction

  task automatic rand_side();
    i_fwd_valid = 2'($urandom_range(0, 3));
    i_fwd_rd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    i_fwd_data  = {$urandom, $urandom};
    i_reg1_data = $urandom;
    i_reg2_data = $urandom;
    i_ret_addr  = $urandom;
  endtask

  // Load one beat into an empty stage and leave it held (i_ready low).
  task automatic inject(input dec_pkt_t p);
    i_pkt   = p;
    i_valid = 1'b1;
    i_ready = 1'b1;
    cycle("inj");
    i_valid = 1'b0;
    i_ready = 1'b0;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("drain");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    dec_pkt_t p;
    i_reset_n = 1'b0;
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_cnt_clr = 1'b0;
    i_pkt = '0;
    i_fwd_valid = '0; i_fwd_rd = '0; i_fwd_data = '0;
    i_reg1_data = '0; i_reg2_data = '0; i_ret_addr = '0;
    m_cnt = 0;
    nid = 0;

    #2;
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_cnt", 64'(o_stall_cnt), 64'(0));
    check("rst_pkt", o_pkt.pc, 64'(0));
    #10 i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    // 1: back-to-back stream with downstream always ready
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_pkt   = rand_pkt(nid++);
    for (int i = 0; i < 8; i++) begin
      rand_side();
      beat_cycle("t1");
    end
    drain();

    // 2: three-cycle backpressure mid-stream fills the skid
    i_cnt_clr = 1'b1;
    cycle("t2clr");
    i_cnt_clr = 1'b0;
    i_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_ready = !(i >= 2 && i < 5);
      rand_side();
      beat_cycle("t2");
    end
    drain();
    check("t2_stall3", 64'(o_stall_cnt), 64'(3));

    // 3: bypass priority and x0
    p = rand_pkt(nid++);
    p.rs1 = 5'd5; p.jal = 1'b0; p.jalr = 1'b0; p.mret = 1'b0; p.branch = 1'b0;
    inject(p);
    i_fwd_valid = 2'b11; i_fwd_rd = {5'd5, 5'd5}; i_fwd_data = {32'h22, 32'h11};
    i_reg1_data = 32'h33;
    #1 check("t3_prio0", 64'(o_reg_data1), 64'h11);
    i_fwd_valid = 2'b10;
    #1 check("t3_prio1", 64'(o_reg_data1), 64'h22);
    i_fwd_valid = 2'b00;
    #1 check("t3_regfile", 64'(o_reg_data1), 64'h33);
    drain();
    p.rs1 = 5'd0;
    inject(p);
    i_fwd_valid = 2'b11; i_fwd_rd = {5'd0, 5'd0}; i_fwd_data = {32'h44, 32'h55};
    i_reg1_data = 32'h66;
    #1 check("t3_x0", 64'(o_reg_data1), 64'h0);
    drain();

    // 4: jalr target with low bit cleared; bit 1 set -> misaligned
    p = rand_pkt(nid++);
    p.rs1 = 5'd3; p.imm_i = 64'd4;
    p.jal = 1'b0; p.jalr = 1'b1; p.mret = 1'b0; p.branch = 1'b0;
    inject(p);
    i_fwd_valid = 2'b01; i_fwd_rd = {5'd0, 5'd3}; i_fwd_data = {32'h0, 32'h1003};
    #1;
    check("t4_target", 64'(o_pc_target), 64'h1006);
    check("t4_misalign", 64'(o_target_misalign), 64'(1));
    check("t4_jj", 64'(o_inst_jal_jalr), 64'(1));
    drain();

    // 5: flush with main and skid full and a beat offered
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_pkt   = rand_pkt(nid++);
    beat_cycle("t5fill");
    beat_cycle("t5fill");
    check("t5_full_ready", 64'(o_ready), 64'(0));
    i_flush = 1'b1;
    beat_cycle("t5flush");
    i_flush = 1'b0;
    check("t5_valid", 64'(o_valid), 64'(0));
    check("t5_ready", 64'(o_ready), 64'(1));
    drain();

    // Random traffic
    i_pkt = rand_pkt(nid++);
    for (int i = 0; i < 400; i++) begin
      i_valid   = ($urandom_range(0, 3) != 0);
      i_ready   = ($urandom_range(0, 9) < 7);
      i_flush   = ($urandom_range(0, 29) == 0);
      i_cnt_clr = ($urandom_range(0, 39) == 0);
      rand_side();
      beat_cycle("rnd");
    end
    i_flush = 1'b0;
    i_cnt_clr = 1'b0;
    drain();

    // 6: counter saturation, then reset asserted during the stall
    i_cnt_clr = 1'b1;
    cycle("t6clr");
    i_cnt_clr = 1'b0;
    i_ready = 1'b0;
    i_valid = 1'b1;
    for (int i = 0; i < 20; i++) beat_cycle("t6");
    check("t6_sat", 64'(o_stall_cnt), 64'(CMAX));
    i_fwd_valid = '0;
    i_reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(o_valid), 64'(0));
    check("t6_rst_cnt", 64'(o_stall_cnt), 64'(0));
    check("t6_rst_pc", o_pkt.pc, 64'(0));
    check("t6_rst_jj", 64'(o_inst_jal_jalr), 64'(0));
    check("t6_rst_mis", 64'(o_target_misalign), 64'(0));
    check("t6_rst_op1", 64'(o_op1), 64'(0));
    check("t6_rst_op2", 64'(o_op2), 64'(0));
    check("t6_rst_tgt", 64'(o_pc_target), 64'(0));
    mq.delete();
    m_cnt = 0;
    i_valid = 1'b0;
    @(negedge i_clk);
    #2 i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
